magic_nmi_ctl: RTL
==================

// Module: magic_nmi_ctl
// PURPOSE
//  Multi-source successor of the magic-mode controller. Latches NMI requests from NSRC sources
//  (magic key, pause key, divmmc, ext), arbitrates them, and drives n_nmi aligned to the INT edge.
//  Tracks entry, signature check, exit and remap of the magic ROM; times out unacknowledged NMIs.
//  Exposes mask, cause and status registers on the magic config port; sits between cpu_bus and the memory mapper.
// PARAMETERS
//  NSRC            4        number of NMI sources, 1..8
//  SIG_BYTE        8'hEB    required first opcode of the magic ROM
//  ENTRY_ADDR      16'h0066 NMI entry fetch address
//  EXIT_ADDR       16'hF000 read here leaves magic mode
//  REMAP_ADDR      16'hF008 read here unmaps for one stretch, remaps on next M1
//  CFG_PORT        8'hFF    low byte of the config I/O port
//  NMI_TIMEOUT     12'd4095 ck35 ticks allowed between n_nmi low and the entry fetch
//  MAGIC_ON_START  1'b1     1: leave reset mapped and in the CHECK state
// PORTS
//  clk28      in   1     system clock
//  rst_n      in   1     async reset, active low
//  ck35       in   1     3.5 MHz enable strobe, one clk28 wide
//  bus_mreq/bus_ioreq/bus_m1/bus_rd/bus_wr  in  1 each  cpu_bus strobes, active high
//  bus_a      in   16    address
//  bus_d      in   8     data
//  n_int      in   1     current INT
//  n_int_next in   1     INT value for the next cycle
//  nmi_req    in   NSRC  level requests, already synchronised; bit0 has highest priority
//  n_nmi      out  1     NMI to CPU, active low
//  magic_mode out  1     magic session active
//  magic_map  out  1     magic ROM/RAM mapped
//  d_out      out  8     readback data
//  d_out_active out 1    d_out valid; drives the bus
// BEHAVIOUR
//  Reset: n_nmi=1; magic_mode=magic_map=MAGIC_ON_START; state=CHECK if MAGIC_ON_START, else IDLE.
//   Reset also clears mask=all 1s, pending, cause, flags, timer, d_out_active=0 and d_out=0.
//  Request latching: a rising edge on nmi_req[i] sets pending[i]. On one bit, a set and a clear in the same cycle -> set wins.
//   Masked bits stay pending but do not dispatch.
//  Dispatch condition: state IDLE, |(pending&mask), and n_int==1 && n_int_next==0.
//   On dispatch: cause <= one-hot of the lowest set bit; that pending bit clears; n_nmi<=0; magic_mode<=1; go to WAIT_ACK.
//   If already in magic_mode, the dispatch is deferred until IDLE.
//  WAIT_ACK: M1&MREQ at ENTRY_ADDR -> n_nmi<=1, magic_map<=1, go to CHECK.
//   Timer counts ck35 ticks. On reaching NMI_TIMEOUT: n_nmi<=1, magic_mode<=0, timeout flag<=1, the cause bit re-enters pending, go to IDLE.
//  CHECK: on MREQ&M1&RD capture match=(bus_d==SIG_BYTE). On the first cycle after that strobe drops:
//   match -> ACTIVE. Mismatch -> magic_mode=magic_map=0, sig_fail<=1, go to IDLE.
//  ACTIVE: MREQ&RD at EXIT_ADDR -> UNMAP; MREQ&RD at REMAP_ADDR -> REMAP_WAIT.
//  UNMAP: first cycle with !bus_mreq -> magic_map=0, magic_mode=0, go to IDLE.
//  REMAP_WAIT: first cycle with !bus_mreq -> magic_map=0. Next M1&MREQ at any address -> magic_map=1, go to ACTIVE, no signature check.
//  Config cs = magic_map & bus_ioreq & bus_a[7:0]==CFG_PORT. Registers by bus_a[15:8]:
//   0x10 RW mask[NSRC-1:0]; unused high bits write-ignored and read 0.
//   0x11 R cause.
//   0x12 R {6'b0,timeout,sig_fail}; writing 1 to a bit clears it. A set event in the same cycle wins.
//   0x13 R pending.
//  Readback: one cycle after cs&rd with a valid index, d_out_active=1 and d_out holds the registered data.
//   Both drop the cycle after cs&rd drops. Other indices never assert d_out_active.
// STRUCTURE
//  common package gains magic_state_t {IDLE,WAIT_ACK,CHECK,ACTIVE,UNMAP,REMAP_WAIT}.
//   It also gains the MAGIC_REG_MASK/CAUSE/STATUS/PEND constants.
//  Sub-module nmi_src_arbiter: edge detect, pending, mask, priority encode, clear/requeue.
//   It is parametrised by NSRC and outputs any_req and grant_onehot.
// TESTING
//  1 MAGIC_ON_START: first M1 fetch reads 0xEB -> ACTIVE, map=1. Repeat with 0x00 -> map=mode=0, status reads 0x01.
//  2 Pulse nmi_req=4'b0110 -> n_nmi low on the INT falling edge only. M1 at 0x0066 -> n_nmi=1.
//   Cause reads 0x02. Exit, then the next INT edge dispatches cause 0x04.
//  3 No entry fetch: n_nmi returns high after 4095 ck35 ticks. Status bit1=1, pending reads back the source bit.
//  4 Write mask 0x00 via port 0x10FF, raise req0 -> no NMI. Write mask 0x01 -> NMI on the next INT edge.
//  5 In ACTIVE read 0xF008 -> map=0 after MREQ drops. Next M1 at 0x1234 -> map=1, state ACTIVE.
//   Read 0xF000 -> map=mode=0.
//  6 Assert rst_n low during WAIT_ACK -> n_nmi=1 and pending cleared immediately (async).

Source files
------------

// File: rtl/magic_nmi_ctl_pkg.sv
// Shared types for the magic NMI controller: FSM states,
// config register indices and a register-index validity helper.
package magic_nmi_ctl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_ACK,
        CHECK,
        ACTIVE,
        UNMAP,
        REMAP_WAIT
    } magic_state_t;

    localparam logic [7:0] MAGIC_REG_MASK   = 8'h10;
    localparam logic [7:0] MAGIC_REG_CAUSE  = 8'h11;
    localparam logic [7:0] MAGIC_REG_STATUS = 8'h12;
    localparam logic [7:0] MAGIC_REG_PEND   = 8'h13;

    // Indices 0x10..0x13 are the only readable registers.
    function automatic logic reg_valid(input logic [7:0] idx);
        return idx[7:2] == 6'b000100;
    endfunction

endpackage

// File: rtl/magic_nmi_ctl_nmi_src_arbiter.sv
// NMI source arbiter: rising-edge latch into pending, mask, lowest-bit
// priority grant, clear on take, requeue of a timed-out cause.
// Ports: clk28, rst_n, req, mask, take, requeue, requeue_vec,
//        pending, any_req, grant_onehot.
module nmi_src_arbiter
    import magic_nmi_ctl_pkg::*;
#(
    parameter int NSRC = 4
) (
    input  logic            clk28,
    input  logic            rst_n,
    input  logic [NSRC-1:0] req,
    input  logic [NSRC-1:0] mask,
    input  logic            take,
    input  logic            requeue,
    input  logic [NSRC-1:0] requeue_vec,
    output logic [NSRC-1:0] pending,
    output logic            any_req,
    output logic [NSRC-1:0] grant_onehot
);

    logic [NSRC-1:0] req_q;
    logic [NSRC-1:0] elig;
    logic [NSRC-1:0] set_vec;
    logic [NSRC-1:0] clr_vec;

    assign elig         = pending & mask;
    assign any_req      = |elig;
    // Two's-complement trick isolates the lowest set bit.
    assign grant_onehot = elig & (~elig + NSRC'(1));

    assign set_vec = (req & ~req_q) | (requeue ? requeue_vec : '0);
    assign clr_vec = take ? grant_onehot : '0;

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            req_q   <= '0;
            pending <= '0;
        end else begin
            req_q   <= req;
            // Set after clear: a simultaneous set wins.
            pending <= (pending & ~clr_vec) | set_vec;
        end
    end

endmodule

// File: rtl/magic_nmi_ctl.sv
// Multi-source magic-mode NMI controller with ROM signature check,
// exit/remap tracking, NMI timeout and a mask/cause/status config port.
// Ports: clk28, rst_n, ck35, bus_* strobes/address/data, n_int,
//        n_int_next, nmi_req -> n_nmi, magic_mode, magic_map,
//        d_out, d_out_active.
module magic_nmi_ctl
    import magic_nmi_ctl_pkg::*;
#(
    parameter int          NSRC           = 4,
    parameter logic [7:0]  SIG_BYTE       = 8'hEB,
    parameter logic [15:0] ENTRY_ADDR     = 16'h0066,
    parameter logic [15:0] EXIT_ADDR      = 16'hF000,
    parameter logic [15:0] REMAP_ADDR     = 16'hF008,
    parameter logic [7:0]  CFG_PORT       = 8'hFF,
    parameter logic [11:0] NMI_TIMEOUT    = 12'd4095,
    parameter logic        MAGIC_ON_START = 1'b1
) (
    input  logic            clk28,
    input  logic            rst_n,
    input  logic            ck35,
    input  logic            bus_mreq,
    input  logic            bus_ioreq,
    input  logic            bus_m1,
    input  logic            bus_rd,
    input  logic            bus_wr,
    input  logic [15:0]     bus_a,
    input  logic [7:0]      bus_d,
    input  logic            n_int,
    input  logic            n_int_next,
    input  logic [NSRC-1:0] nmi_req,
    output logic            n_nmi,
    output logic            magic_mode,
    output logic            magic_map,
    output logic [7:0]      d_out,
    output logic            d_out_active
);

    magic_state_t    state;
    logic [NSRC-1:0] mask;
    logic [NSRC-1:0] cause;
    logic [NSRC-1:0] pending;
    logic [NSRC-1:0] grant;
    logic            any_req;
    logic [11:0]     timer;
    logic            match;
    logic            seen;
    logic            timeout;
    logic            sig_fail;

    logic       fetch, sig_strobe, mem_rd, entry;
    logic       dispatch, tmo_evt, sig_evt;
    logic       cs, rd_ok, wr_mask, wr_stat;
    logic [7:0] idx;
    logic [7:0] rd_data;

    assign fetch      = bus_m1 & bus_mreq;
    assign sig_strobe = fetch & bus_rd;
    assign mem_rd     = bus_mreq & bus_rd;
    assign entry      = fetch & (bus_a == ENTRY_ADDR);

    assign dispatch = (state == IDLE) & any_req & n_int & ~n_int_next;
    assign tmo_evt  = (state == WAIT_ACK) & ~entry & ck35
                    & (timer == NMI_TIMEOUT - 12'd1);
    // Mismatch resolves on the first cycle after the fetch strobe.
    assign sig_evt  = (state == CHECK) & ~sig_strobe & seen & ~match;

    assign idx     = bus_a[15:8];
    assign cs      = magic_map & bus_ioreq & (bus_a[7:0] == CFG_PORT);
    assign rd_ok   = cs & bus_rd & reg_valid(idx);
    assign wr_mask = cs & bus_wr & (idx == MAGIC_REG_MASK);
    assign wr_stat = cs & bus_wr & (idx == MAGIC_REG_STATUS);

    nmi_src_arbiter #(.NSRC(NSRC)) u_arb (
        .clk28        (clk28),
        .rst_n        (rst_n),
        .req          (nmi_req),
        .mask         (mask),
        .take         (dispatch),
        .requeue      (tmo_evt),
        .requeue_vec  (cause),
        .pending      (pending),
        .any_req      (any_req),
        .grant_onehot (grant)
    );

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= MAGIC_ON_START ? CHECK : IDLE;
            n_nmi      <= 1'b1;
            magic_mode <= MAGIC_ON_START;
            magic_map  <= MAGIC_ON_START;
            cause      <= '0;
            timer      <= '0;
            match      <= 1'b0;
            seen       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (dispatch) begin
                    cause      <= grant;
                    n_nmi      <= 1'b0;
                    magic_mode <= 1'b1;
                    timer      <= '0;
                    state      <= WAIT_ACK;
                end
                WAIT_ACK: if (entry) begin
                    n_nmi     <= 1'b1;
                    magic_map <= 1'b1;
                    seen      <= 1'b0;
                    state     <= CHECK;
                end else if (tmo_evt) begin
                    n_nmi      <= 1'b1;
                    magic_mode <= 1'b0;
                    state      <= IDLE;
                end else if (ck35) begin
                    timer <= timer + 12'd1;
                end
                CHECK: if (sig_strobe) begin
                    match <= (bus_d == SIG_BYTE);
                    seen  <= 1'b1;
                end else if (seen) begin
                    seen <= 1'b0;
                    if (match) begin
                        state <= ACTIVE;
                    end else begin
                        magic_mode <= 1'b0;
                        magic_map  <= 1'b0;
                        state      <= IDLE;
                    end
                end
                ACTIVE: if (mem_rd && bus_a == EXIT_ADDR) begin
                    state <= UNMAP;
                end else if (mem_rd && bus_a == REMAP_ADDR) begin
                    state <= REMAP_WAIT;
                end
                UNMAP: if (!bus_mreq) begin
                    magic_map  <= 1'b0;
                    magic_mode <= 1'b0;
                    state      <= IDLE;
                end
                // magic_map doubles as the "already unmapped" phase flag.
                REMAP_WAIT: if (magic_map) begin
                    if (!bus_mreq) magic_map <= 1'b0;
                end else if (fetch) begin
                    magic_map <= 1'b1;
                    state     <= ACTIVE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            mask     <= '1;
            timeout  <= 1'b0;
            sig_fail <= 1'b0;
        end else begin
            if (wr_mask) mask <= bus_d[NSRC-1:0];
            timeout  <= tmo_evt
                      | (timeout & ~(wr_stat & bus_d[1]));
            sig_fail <= sig_evt
                      | (sig_fail & ~(wr_stat & bus_d[0]));
        end
    end

    always_comb begin
        rd_data = 8'h00;
        unique case (1'b1)
            (idx == MAGIC_REG_MASK):   rd_data = 8'(mask);
            (idx == MAGIC_REG_CAUSE):  rd_data = 8'(cause);
            (idx == MAGIC_REG_STATUS): rd_data = {6'b0, timeout, sig_fail};
            (idx == MAGIC_REG_PEND):   rd_data = 8'(pending);
            default:                   rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            d_out_active <= 1'b0;
            d_out        <= 8'h00;
        end else begin
            d_out_active <= rd_ok;
            d_out        <= rd_ok ? rd_data : 8'h00;
        end
    end

endmodule
